// File: rtl/seq_divider_if.sv
// seq_divider_if: handshake and operand/result bundle for seq_divider.
//   master : drives start, is_signed, dividend, divisor; observes results
//   slave  : the divider itself
//   start/is_signed/dividend/divisor : request, sampled when busy=0
//   quotient/remainder/div_by_zero   : registered results, held until next done
//   busy/done                        : busy while dividing, done is a 1-cycle pulse
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed (DIV) or
// unsigned (DIVU), fixed latency WIDTH+2 cycles from accepted start to done.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : seq_divider_if slave (start/is_signed/dividend/divisor in,
//          quotient/remainder/busy/done/div_by_zero out)
//
// state  | meaning
// IDLE   | waiting for start; results held
// CALC   | one restoring step per cycle, WIDTH cycles
// FIX    | apply signs / divide-by-zero override, publish results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] dsor;
  logic             q_neg;
  logic             r_neg;
  logic             zero;

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             done_q;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Magnitudes are taken as unsigned WIDTH-bit values so |MIN| = 2^(WIDTH-1)
  // fits without overflow.
  always_comb begin
    dvd_mag = bus.dividend;
    dsr_mag = bus.divisor;
    if (bus.is_signed && bus.dividend[WIDTH-1]) dvd_mag = -bus.dividend;
    if (bus.is_signed && bus.divisor[WIDTH-1])  dsr_mag = -bus.divisor;
  end

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits; the extra top bit of trial is the borrow/sign.
  always_comb begin
    shifted = {prem, dreg[WIDTH-1]};
    trial   = shifted - {2'b00, dsor};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prem   <= '0;
      dreg   <= '0;
      dsor   <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      zero   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dreg  <= dvd_mag;
            dsor  <= dsr_mag;
            q_neg <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            r_neg <= bus.is_signed && bus.dividend[WIDTH-1];
            zero  <= (bus.divisor == '0);
            prem  <= '0;
            cnt   <= CNT_W'(WIDTH);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (!trial[WIDTH+1]) begin
            prem <= trial[WIDTH:0];
            dreg <= {dreg[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted[WIDTH:0];
            dreg <= {dreg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (zero) begin
            quo_q <= '0;
            rem_q <= '0;
          end else begin
            quo_q <= q_neg ? -dreg : dreg;
            rem_q <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          end
          dbz_q  <= zero;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider (WIDTH=32).
module tb_seq_divider;
  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;   // edges after the accepting edge until done

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present a request and let the next edge accept it; returns #1 after that edge.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done, expecting it exactly 'edges' edges from now; busy must stay
  // high until then and drop in the done cycle.
  task automatic wait_done(input string tag, input int edges);
    int  n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (1) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1 || n > edges + 8) break;
    end
    check({tag, "_latency"}, n, edges);
    check({tag, "_busy_during"}, {31'b0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ez);
    launch(sgn, a, b);
    wait_done(tag, LAT);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
    check({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, ez});
  endtask

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  initial begin
    logic [31:0] eq, er, a, b;
    logic        sgn;
    int          n;
    logic        saw_done;

    n_checks      = 0;
    n_errors      = 0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    check("done_pulse", {31'b0, bus.done}, 32'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);
    check("q_held", bus.quotient, 32'd14);

    run("sm7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run("s7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
    run("sm7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0);

    run("u5_0", 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
    run("s5_0", 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1);
    run("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    run("smin_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
    run("umin_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run("umax_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);

    // Start while busy is ignored; results are not touched at start.
    launch(1'b0, 32'd50, 32'd5);
    check("no_change_at_start", bus.quotient, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b1;
    bus.dividend  = 32'd1;
    bus.divisor   = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("ignored_start", LAT - 5);
    check("ignored_start_q", bus.quotient, 32'd10);
    check("ignored_start_r", bus.remainder, 32'd0);

    // Reset mid-flight discards the division.
    launch(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_q", bus.quotient, 32'd0);
    check("midrst_r", bus.remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'b0, saw_done}, 32'd0);
    run("after_rst", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

    // Back-to-back: new start issued in the done cycle.
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("b2b_first", LAT);
    check("b2b_first_q", bus.quotient, 32'hFFFF_FFF2);
    check("b2b_first_r", bus.remainder, 32'hFFFF_FFFE);
    launch(1'b0, 32'd1000, 32'd33);
    wait_done("b2b_second", LAT);
    check("b2b_second_q", bus.quotient, 32'd30);
    check("b2b_second_r", bus.remainder, 32'd10);

    for (int i = 0; i < 8; i++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom();
      b   = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom();
      if ($urandom_range(0, 1) == 1) b = -b;
      if (i == 5) b = 32'd0;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      ref_div(sgn, a, b, eq, er);
      run($sformatf("rand%0d", i), sgn, a, b, eq, er, (b == 32'd0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
